i2c_slave_regs: RTL and testbench

I2C slave endpoint with a small pointer-addressed register file. It sits directly downstream of the I2C master, on the same Scl/Sda bus. It consumes address, pointer and data bytes from the master, and answers read requests with register contents. It oversamples Scl/Sda on its own system clock; it never drives Scl (no clock stretching).

---
 rtl/i2c_slave_regs_if.sv | 13 +
 rtl/i2c_slave_regs.sv | 194 +++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regs_if.sv
// Local register-side port bundle of i2c_slave_regs: read select, read data,
// write strobe/index and bus status flags.
interface i2c_slave_regs_if;
  logic [3:0] Reg_sel;
  logic [7:0] Reg_data;
  logic       Wr_pulse;
  logic [3:0] Wr_idx;
  logic       Busy;
  logic       Nack_err;

  modport slave  (input  Reg_sel, output Reg_data, Wr_pulse, Wr_idx, Busy, Nack_err);
  modport master (output Reg_sel, input  Reg_data, Wr_pulse, Wr_idx, Busy, Nack_err);
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave with a pointer-addressed register file, oversampling Scl/Sda on Clk.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer after each data byte.
module i2c_slave_regs #(
  parameter logic [6:0] SLV_ADR = 7'h48,
  parameter int         NREGS   = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Scl,
  inout  wire  Sda,
  i2c_slave_regs_if.slave lb
);
  localparam int PW = $clog2(NREGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t                     state, state_n;
  logic [2:0]                 scl_s, sda_s;
  logic [2:0]                 bit_cnt, bit_cnt_n;
  logic [7:0]                 shreg, shreg_n;
  logic [PW-1:0]              ptr, ptr_n;
  logic [NREGS-1:0][7:0]      regs;
  logic                       oe, oe_n;
  logic                       ack_on, ack_on_n;
  logic                       busy, busy_n;
  logic                       wr_en, nack_n;
  logic [7:0]                 rx_byte;
  logic                       scl_rise, scl_fall, sda_rise, sda_fall;
  logic                       start_det, stop_det;
  logic                       unused_bits;

  // [0],[1] synchronize, [2] holds the previous synced value for edge detection
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      scl_s <= 3'b111;
      sda_s <= 3'b111;
    end else begin
      scl_s <= {scl_s[1:0], Scl};
      sda_s <= {sda_s[1:0], Sda};
    end
  end

  assign scl_rise  =  scl_s[1] & ~scl_s[2];
  assign scl_fall  = ~scl_s[1] &  scl_s[2];
  assign sda_rise  =  sda_s[1] & ~sda_s[2];
  assign sda_fall  = ~sda_s[1] &  sda_s[2];
  assign start_det =  sda_fall &  scl_s[1];
  assign stop_det  =  sda_rise &  scl_s[1];
  assign rx_byte   = {shreg[6:0], sda_s[1]};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      regs        <= '0;
      oe          <= 1'b0;
      ack_on      <= 1'b0;
      busy        <= 1'b0;
      lb.Wr_pulse <= 1'b0;
      lb.Wr_idx   <= '0;
      lb.Nack_err <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      ptr         <= ptr_n;
      oe          <= oe_n;
      ack_on      <= ack_on_n;
      busy        <= busy_n;
      lb.Wr_pulse <= wr_en;
      lb.Nack_err <= nack_n;
      if (wr_en) begin
        regs[ptr] <= rx_byte;
        lb.Wr_idx <= 4'(ptr);
      end
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    oe_n      = oe;
    ack_on_n  = ack_on;
    busy_n    = busy;
    wr_en     = 1'b0;
    nack_n    = 1'b0;
    if (stop_det) begin
      state_n  = IDLE;
      oe_n     = 1'b0;
      ack_on_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      oe_n      = 1'b0;
      ack_on_n  = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shreg_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ADDR) begin
                state_n = (rx_byte[7:1] == SLV_ADR) ? ADDR_ACK : IDLE;
              end else if (state == PTR) begin
                if (rx_byte < 8'(NREGS)) begin
                  ptr_n   = rx_byte[PW-1:0];
                  state_n = PTR_ACK;
                end else begin
                  nack_n  = 1'b1;
                  state_n = IDLE;
                end
              end else begin
                wr_en   = 1'b1;
                state_n = WDATA_ACK;
`ifdef I2C_SLAVE_AUTOINC_EN
                ptr_n   = ptr + PW'(1);
`endif
              end
            end
          end
        end
        // First fall after the 8th bit pulls Sda low, the next one releases it
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on) begin
              oe_n     = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              ack_on_n  = 1'b0;
              oe_n      = 1'b0;
              bit_cnt_n = '0;
              if (state == ADDR_ACK && shreg[0]) begin
                shreg_n = regs[ptr];
                oe_n    = ~regs[ptr][7];
                state_n = RDATA;
              end else if (state == ADDR_ACK) begin
                state_n = PTR;
              end else begin
                state_n = WDATA;
              end
            end
          end
        end
        // bit_cnt counts master sampling rises; wrap to 0 marks the byte done
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              oe_n    = 1'b0;
              state_n = RACK;
            end else begin
              shreg_n = {shreg[6:0], 1'b0};
              oe_n    = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise && !ack_on) begin
            if (sda_s[1]) begin
              state_n = IDLE;
            end else begin
              ack_on_n = 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
              ptr_n    = ptr + PW'(1);
`endif
            end
          end else if (scl_fall && ack_on) begin
            ack_on_n  = 1'b0;
            shreg_n   = regs[ptr];
            oe_n      = ~regs[ptr][7];
            bit_cnt_n = '0;
            state_n   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sda         = oe ? 1'b0 : 1'bz;
  assign lb.Busy     = busy;
  assign lb.Reg_data = regs[lb.Reg_sel[PW-1:0]];
  assign unused_bits = ^{lb.Reg_sel, shreg[7]};
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master, a table of
// single-byte write vectors and hand sequences for reads, NACKs and reset.
module tb_i2c_slave_regs;
  localparam time Q = 50ns;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regs_if bus();

  i2c_slave_regs dut (.Clk(Clk), .Rst(Rst), .Scl(scl_m), .Sda(sda), .lb(bus));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  int wr_total = 0, nack_total = 0, drv_total = 0;
  int wr_idx_log[$];
  logic [7:0] model [4];

  always @(negedge Clk) begin
    if (bus.Wr_pulse) begin
      wr_total <= wr_total + 1;
      wr_idx_log.push_back(int'(bus.Wr_idx));
    end
    if (bus.Nack_err) nack_total <= nack_total + 1;
    if (!sda_low && sda === 1'b0) drv_total <= drv_total + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input int idx);
    bus.Reg_sel = 4'(idx);
    #1;
    chk($sformatf("reg_data[%0d]", idx), int'(bus.Reg_data), int'(model[idx]));
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_low = 1'b0; #Q;
      scl_m = 1'b1;   #Q;
    end
    sda_low = 1'b1; #Q;
    scl_m = 1'b0;   #Q;
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; #Q;
    scl_m = 1'b1;   #Q;
    sda_low = 1'b0; #(2*Q);
  endtask

  task automatic wbit(input logic b);
    sda_low = ~b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    sda_low = 1'b0; #Q;
    scl_m = 1'b1;   #Q;
    b = sda;        #Q;
    scl_m = 1'b0;   #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic mack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(mack);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ptr_ack;
    logic       exp_dat_ack;
    int         exp_nack;
    int         exp_wr;
    int         sel;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] rd;
    int w0, n0, d0;

    vecs[0] = '{8'h00, 8'h11, 1'b0, 1'b0, 0, 1, 0};
    vecs[1] = '{8'h01, 8'h22, 1'b0, 1'b0, 0, 1, 1};
    vecs[2] = '{8'h02, 8'h33, 1'b0, 1'b0, 0, 1, 2};
    vecs[3] = '{8'h03, 8'h44, 1'b0, 1'b0, 0, 1, 3};
    vecs[4] = '{8'h07, 8'h99, 1'b1, 1'b1, 1, 0, 3};
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    bus.Reg_sel = 4'd0;

    repeat (4) @(posedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #2;

    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_wr_pulse", int'(bus.Wr_pulse), 0);
    chk("rst_wr_idx", int'(bus.Wr_idx), 0);
    chk("rst_nack_err", int'(bus.Nack_err), 0);
    chk("rst_sda", int'(sda === 1'b1), 1);
    for (int i = 0; i < 4; i++) chk_reg(i);

    // Table: one write transaction per vector
    for (int v = 0; v < 5; v++) begin
      w0 = wr_total; n0 = nack_total;
      i2c_start();
      chk($sformatf("v%0d_busy", v), int'(bus.Busy), 1);
      wbyte(8'h90, a0);
      wbyte(vecs[v].ptr, a1);
      wbyte(vecs[v].data, a2);
      i2c_stop();
      #(4*Q);
      if (vecs[v].exp_wr != 0) model[vecs[v].ptr[1:0]] = vecs[v].data;
      chk($sformatf("v%0d_addr_ack", v), int'(a0), 0);
      chk($sformatf("v%0d_ptr_ack", v), int'(a1), int'(vecs[v].exp_ptr_ack));
      chk($sformatf("v%0d_dat_ack", v), int'(a2), int'(vecs[v].exp_dat_ack));
      chk($sformatf("v%0d_nack_err", v), nack_total - n0, vecs[v].exp_nack);
      chk($sformatf("v%0d_wr_cnt", v), wr_total - w0, vecs[v].exp_wr);
      chk($sformatf("v%0d_busy_end", v), int'(bus.Busy), 0);
      chk_reg(vecs[v].sel);
    end

    // Read two bytes from ptr 3: ACK then NACK
    i2c_start(); wbyte(8'h90, a0); wbyte(8'h03, a1); i2c_stop();
    i2c_start(); wbyte(8'h91, a2);
    chk("rd_addr_ack", int'(a2), 0);
    rbyte(rd, 1'b0);
    chk("rd_byte0", int'(rd), int'(model[3]));
    rbyte(rd, 1'b1);
`ifdef I2C_SLAVE_AUTOINC_EN
    chk("rd_byte1", int'(rd), int'(model[0]));
`else
    chk("rd_byte1", int'(rd), int'(model[3]));
`endif
    chk("rd_sda_released", int'(sda === 1'b1), 1);
    i2c_stop();

    // Multi-byte write at ptr 1
    w0 = wr_total;
    wr_idx_log.delete();
    i2c_start(); wbyte(8'h90, a0); wbyte(8'h01, a1); wbyte(8'hA5, a2); wbyte(8'h3C, a3); i2c_stop();
    #(4*Q);
`ifdef I2C_SLAVE_AUTOINC_EN
    model[1] = 8'hA5; model[2] = 8'h3C;
`else
    model[1] = 8'h3C;
`endif
    chk("mw_acks", int'({a0, a1, a2, a3}), 0);
    chk("mw_wr_cnt", wr_total - w0, 2);
    if (wr_idx_log.size() >= 2) begin
      chk("mw_idx0", wr_idx_log[0], 1);
`ifdef I2C_SLAVE_AUTOINC_EN
      chk("mw_idx1", wr_idx_log[1], 2);
`else
      chk("mw_idx1", wr_idx_log[1], 1);
`endif
    end
    chk_reg(1);
    chk_reg(2);

    // Wrong address: no drive, no write, Busy until STOP
    w0 = wr_total; d0 = drv_total;
    i2c_start(); wbyte(8'h92, a0); wbyte(8'h01, a1); wbyte(8'hEE, a2);
    chk("bad_busy_before_stop", int'(bus.Busy), 1);
    i2c_stop();
    #(4*Q);
    chk("bad_addr_ack", int'(a0), 1);
    chk("bad_sda_driven", drv_total - d0, 0);
    chk("bad_wr_cnt", wr_total - w0, 0);
    chk("bad_busy_after_stop", int'(bus.Busy), 0);

    // Pointer 2, repeated START, read
    i2c_start(); wbyte(8'h90, a0); wbyte(8'h02, a1);
    i2c_start();
    chk("sr_busy", int'(bus.Busy), 1);
    wbyte(8'h91, a2);
    rbyte(rd, 1'b1);
    i2c_stop();
    chk("sr_acks", int'({a0, a1, a2}), 0);
    chk("sr_data", int'(rd), int'(model[2]));

    // Reset during the 5th bit of a data byte
    w0 = wr_total;
    i2c_start(); wbyte(8'h90, a0); wbyte(8'h00, a1);
    for (int i = 7; i >= 4; i--) wbit(1'b1);
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #2;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    for (int i = 3; i >= 0; i--) wbit(1'b1);
    rbit(a2);
    i2c_stop();
    #(4*Q);
    chk("rst_mid_ack", int'(a2), 1);
    chk("rst_mid_wr_cnt", wr_total - w0, 0);
    chk("rst_mid_busy", int'(bus.Busy), 0);
    chk_reg(0);
    chk_reg(3);
    i2c_start(); wbyte(8'h90, a0); wbyte(8'h00, a1); wbyte(8'h5A, a2); i2c_stop();
    #(4*Q);
    model[0] = 8'h5A;
    chk("post_rst_acks", int'({a0, a1, a2}), 0);
    chk("post_rst_wr_cnt", wr_total - w0, 1);
    chk_reg(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
